// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared state encoding and settle-counter width for the sweeper
package truth_table_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
  localparam int SETTLE_W = 4;
endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: loadable down-counter; expired when it has reached zero and is not being reloaded
module settle_timer
  import truth_table_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expired
);
  logic [SETTLE_W-1:0] count;
  always_ff @(posedge clock)
    count <= reset ? '0 : load ? load_val : (count == '0) ? count : count - 1'b1;
  assign expired = count == '0 && !load;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector, samples two implementations and records both truth tables
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_INPUTS = 3,
  parameter int SETTLE   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   s_a,
  input  logic                   s_b,
  output logic [N_INPUTS-1:0]    vars,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [N_INPUTS-1:0]    first_bad,
  output logic [2**N_INPUTS-1:0] table_a,
  output logic [2**N_INPUTS-1:0] table_b
);
  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);
  state_t state, state_nx;
  logic accept, last, load, expired;
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign last   = vars == '1;
  assign load   = accept || (state == ST_SAMPLE && !last);
  assign busy   = state == ST_DRIVE || state == ST_SAMPLE;
  assign done   = state == ST_DONE;
  settle_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (RELOAD),
    .expired  (expired)
  );
  always_ff @(posedge clock)
    state <= reset ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = accept                          ? ST_DRIVE  :
               (state == ST_DRIVE && expired)  ? ST_SAMPLE :
               (state == ST_SAMPLE)            ? (last ? ST_DONE : ST_DRIVE) :
                                                 state;
  end
  // Capture happens on the SAMPLE exit edge; only the first disagreement sets first_bad
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      vars      <= '0;
      first_bad <= '0;
      table_a   <= '0;
      table_b   <= '0;
      mismatch  <= 1'b0;
    end else if (state == ST_SAMPLE) begin
      table_a[vars] <= s_a;
      table_b[vars] <= s_b;
      if (s_a != s_b && !mismatch) begin
        mismatch  <= 1'b1;
        first_bad <= vars;
      end
      if (!last) vars <= vars + 1'b1;
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scenario tasks with a queue of expected sweep results checked at DONE
module tb_truth_table_sweeper;
  typedef struct packed {
    logic [7:0] ta;
    logic [7:0] tb;
    logic       mm;
    logic [2:0] fb;
  } exp_t;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, start3 = 1'b0;
  logic s_a, s_b, s_a3, s_b3;
  logic [2:0] vars, first_bad, vars3, first_bad3;
  logic busy, done, mismatch, busy3, done3, mismatch3;
  logic [7:0] table_a, table_b, table_a3, table_b3;
  int mode_a = 0, mode_b = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t q[$];

  always #5 clock = ~clock;

  function automatic logic fn(int m, logic [2:0] v);
    return (m == 0) ? v[2] ^ v[1] : (m == 1) ? v[2] & (~v[1] | v[0]) : v[2] & ~v[1];
  endfunction

  function automatic exp_t model(int ma, int mb);
    exp_t e;
    logic a, b;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      a = fn(ma, 3'(i));
      b = fn(mb, 3'(i));
      e.ta[i] = a;
      e.tb[i] = b;
      if (a != b && !e.mm) begin
        e.mm = 1'b1;
        e.fb = 3'(i);
      end
    end
    return e;
  endfunction

  always_comb begin
    s_a  = fn(mode_a, vars);
    s_b  = fn(mode_b, vars);
    s_a3 = fn(0, vars3);
    s_b3 = fn(0, vars3);
  end

  truth_table_sweeper dut (
    .clock(clock), .reset(reset), .start(start), .s_a(s_a), .s_b(s_b),
    .vars(vars), .busy(busy), .done(done), .mismatch(mismatch),
    .first_bad(first_bad), .table_a(table_a), .table_b(table_b)
  );

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .s_a(s_a3), .s_b(s_b3),
    .vars(vars3), .busy(busy3), .done(done3), .mismatch(mismatch3),
    .first_bad(first_bad3), .table_a(table_a3), .table_b(table_b3)
  );

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({vars, first_bad, table_a, table_b} !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_regs: got vars=%h fb=%h ta=%h tb=%h, want all 0", vars, first_bad, table_a, table_b);
    end
    n_cmp++;
    if ({busy, done, mismatch} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got busy=%b done=%b mm=%b, want 000", busy, done, mismatch);
    end
    n_cmp++;
    if ({busy3, done3, vars3} !== 5'h0) begin
      n_bad++;
      $display("FAIL reset_dut3: got busy=%b done=%b vars=%h, want 0", busy3, done3, vars3);
    end
  endtask

  task automatic test_reset_mid_sweep;
    mode_a = 0;
    mode_b = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (8) @(negedge clock);
    n_cmp++;
    if (vars !== 3'd4 || table_a !== 8'h0C || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_sweep_state: got vars=%h ta=%h busy=%b, want vars=4 ta=0c busy=1", vars, table_a, busy);
    end
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    n_cmp++;
    if ({vars, table_a, busy, done, mismatch} !== 14'h0) begin
      n_bad++;
      $display("FAIL mid_sweep_reset: got vars=%h ta=%h busy=%b done=%b mm=%b, want all 0", vars, table_a, busy, done, mismatch);
    end
  endtask

  task automatic run_sweep(input int ma, input int mb, input string nm);
    exp_t e;
    int cyc, nbusy;
    mode_a = ma;
    mode_b = mb;
    q.push_back(model(ma, mb));
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    n_cmp++;
    if ({table_a, table_b, mismatch, first_bad, vars, busy, done} !== {16'h0, 1'b0, 3'h0, 3'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_accept: got ta=%h tb=%h mm=%b fb=%h vars=%h busy=%b done=%b, want cleared busy=1",
               nm, table_a, table_b, mismatch, first_bad, vars, busy, done);
    end
    cyc = 0;
    nbusy = 0;
    while (!done && cyc < 500) begin
      nbusy += int'(busy);
      @(negedge clock);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 16 || nbusy !== 16) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles (%0d busy), want 16/16", nm, cyc, nbusy);
    end
    e = q.pop_front();
    n_cmp++;
    if (table_a !== e.ta || table_b !== e.tb) begin
      n_bad++;
      $display("FAIL %s_tables: got ta=%h tb=%h, want ta=%h tb=%h", nm, table_a, table_b, e.ta, e.tb);
    end
    n_cmp++;
    if (mismatch !== e.mm || busy !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_flags: got mm=%b busy=%b done=%b, want mm=%b busy=0 done=1", nm, mismatch, busy, done, e.mm);
    end
    if (e.mm) begin
      n_cmp++;
      if (first_bad !== e.fb) begin
        n_bad++;
        $display("FAIL %s_first_bad: got %h, want %h", nm, first_bad, e.fb);
      end
    end
  endtask

  task automatic test_xor;        run_sweep(0, 0, "xor");      endtask
  task automatic test_reference;  run_sweep(1, 1, "ref");      endtask
  task automatic test_mismatch;   run_sweep(1, 2, "mismatch"); endtask
  task automatic test_restart;    run_sweep(1, 1, "restart");  endtask

  task automatic test_settle;
    exp_t e;
    int cyc, run;
    logic [2:0] prev;
    q.push_back(model(0, 0));
    @(negedge clock) start3 = 1'b1;
    @(negedge clock) start3 = 1'b0;
    cyc = 0;
    run = 0;
    prev = vars3;
    while (!done3 && cyc < 500) begin
      start3 = (cyc == 5 || cyc == 20);
      @(negedge clock);
      cyc++;
      run++;
      if (vars3 !== prev) begin
        n_cmp++;
        if (run !== 4 || vars3 !== 3'(prev + 1)) begin
          n_bad++;
          $display("FAIL settle_hold: vars %h held %0d cycles then %h, want 4 cycles then %h", prev, run, vars3, 3'(prev + 1));
        end
        prev = vars3;
        run = 0;
      end
    end
    start3 = 1'b0;
    n_cmp++;
    if (cyc !== 32 || vars3 !== 3'd7) begin
      n_bad++;
      $display("FAIL settle_latency: got %0d cycles vars=%h, want 32 vars=7", cyc, vars3);
    end
    e = q.pop_front();
    n_cmp++;
    if (table_a3 !== e.ta || table_b3 !== e.tb || mismatch3 !== e.mm) begin
      n_bad++;
      $display("FAIL settle_tables: got ta=%h tb=%h mm=%b, want ta=%h tb=%h mm=%b", table_a3, table_b3, mismatch3, e.ta, e.tb, e.mm);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_sweep;
    test_xor;
    test_reference;
    test_mismatch;
    test_restart;
    test_settle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
